// File: rtl/gol_pkg.sv
// Shared types and constants for the Game-of-Life frame reader.
package gol_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_e;

    localparam int unsigned GEN_CNT_W = 16;

endpackage

// File: rtl/gol_frame_reader_if.sv
// Row stream from the frame reader to its consumer (valid/ready handshake).
interface gol_frame_reader_if #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned HEIGHT = 8
);

    logic [WIDTH-1:0]           row_data;
    logic [$clog2(HEIGHT)-1:0]  row_idx;
    logic                       row_valid;
    logic                       row_ready;
    logic                       frame_last;

    modport master (
        output row_data,
        output row_idx,
        output row_valid,
        output frame_last,
        input  row_ready
    );

    modport slave (
        input  row_data,
        input  row_idx,
        input  row_valid,
        input  frame_last,
        output row_ready
    );

endinterface

// File: rtl/gol_popcount.sv
// Combinational population count of an N-bit vector.
module gol_popcount #(
    parameter int unsigned N = 64
) (
    input  logic [N-1:0]             in_bits,
    output logic [$clog2(N+1)-1:0]   count
);

    localparam int unsigned CW = $clog2(N + 1);

    always_comb begin
        count = '0;
        for (int unsigned i = 0; i < N; i++) begin
            count = count + CW'(in_bits[i]);
        end
    end

endmodule

// File: rtl/gol_frame_reader.sv
// Snapshots the cell array on gen_tick and streams it out row by row.
// Optional population output is enabled by defining GOL_POPCOUNT_EN.
module gol_frame_reader
    import gol_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned HEIGHT = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         gen_tick,
    input  logic [WIDTH*HEIGHT-1:0]      cells,
    gol_frame_reader_if.master           row_if,
    output logic                         busy,
    output logic                         overrun,
    output logic [GEN_CNT_W-1:0]         gen_count
`ifdef GOL_POPCOUNT_EN
    ,
    output logic [$clog2(WIDTH*HEIGHT+1)-1:0] population
`endif
);

    localparam int unsigned PTR_W = $clog2(HEIGHT);
    localparam logic [PTR_W-1:0] LAST_ROW = PTR_W'(HEIGHT - 1);

    state_e                           state_q, state_d;
    logic [PTR_W-1:0]                 ptr_q, ptr_d;
    logic [HEIGHT-1:0][WIDTH-1:0]     snap_q, snap_d;
    logic [GEN_CNT_W-1:0]             gen_count_q, gen_count_d;
    logic                             overrun_q, overrun_d;

    logic xfer, last_xfer, accept, drop;

    // A tick is only taken when the reader is free, or frees up on this very edge.
    always_comb begin
        xfer      = (state_q == STREAM) && row_if.row_ready;
        last_xfer = xfer && (ptr_q == LAST_ROW);
        accept    = gen_tick && ((state_q == IDLE) || last_xfer);
        drop      = gen_tick && (state_q == STREAM) && !last_xfer;
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = STREAM;
            STREAM:  if (last_xfer && !accept) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        row_if.row_valid  = (state_q == STREAM);
        row_if.frame_last = (state_q == STREAM) && (ptr_q == LAST_ROW);
        row_if.row_idx    = ptr_q;
        row_if.row_data   = snap_q[ptr_q];
        busy              = (state_q == STREAM);
        overrun           = overrun_q;
        gen_count         = gen_count_q;
    end

    // Datapath next values
    always_comb begin
        ptr_d       = ptr_q;
        snap_d      = snap_q;
        gen_count_d = gen_count_q;
        overrun_d   = overrun_q | drop;
        if (accept) begin
            ptr_d       = '0;
            snap_d      = cells;
            gen_count_d = gen_count_q + GEN_CNT_W'(1);
        end else if (xfer) begin
            ptr_d = last_xfer ? '0 : ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q       <= '0;
            snap_q      <= '0;
            gen_count_q <= '0;
            overrun_q   <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            snap_q      <= snap_d;
            gen_count_q <= gen_count_d;
            overrun_q   <= overrun_d;
        end
    end

`ifdef GOL_POPCOUNT_EN
    gol_popcount #(
        .N (WIDTH * HEIGHT)
    ) u_popcount (
        .in_bits (snap_q),
        .count   (population)
    );
`endif

endmodule

// File: tb/tb_gol_frame_reader.sv
// Scoreboard bench for gol_frame_reader at WIDTH=4, HEIGHT=4.
module tb_gol_frame_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        gen_tick;
    logic [15:0] cells;
    logic        busy;
    logic        overrun;
    logic [15:0] gen_count;
`ifdef GOL_POPCOUNT_EN
    logic [4:0]  population;
`endif

    int vectors     = 0;
    int miscompares = 0;
    logic [15:0] exp_gen = '0;

    typedef struct {
        logic [1:0] idx;
        logic [3:0] data;
        logic       last;
    } row_t;

    row_t exp_q[$];

    gol_frame_reader_if #(.WIDTH(4), .HEIGHT(4)) row_if ();

    gol_frame_reader #(
        .WIDTH  (4),
        .HEIGHT (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .gen_tick   (gen_tick),
        .cells      (cells),
        .row_if     (row_if),
        .busy       (busy),
        .overrun    (overrun),
        .gen_count  (gen_count)
`ifdef GOL_POPCOUNT_EN
        ,
        .population (population)
`endif
    );

    always #5 clk = ~clk;

    // Transfers are sampled on the falling edge, half a cycle before they commit.
    always @(negedge clk) begin
        if (!reset && row_if.row_valid && row_if.row_ready) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_row: got idx=%0d data=%h, required no row", row_if.row_idx, row_if.row_data);
            end else begin
                row_t e;
                e = exp_q.pop_front();
                if ({row_if.row_idx, row_if.row_data, row_if.frame_last} !== {e.idx, e.data, e.last}) begin
                    miscompares++;
                    $display("FAIL row: got idx=%0d data=%h last=%b, required idx=%0d data=%h last=%b",
                             row_if.row_idx, row_if.row_data, row_if.frame_last, e.idx, e.data, e.last);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [15:0] c);
        for (int r = 0; r < 4; r++) begin
            row_t e;
            e.idx  = 2'(r);
            e.data = c[r*4 +: 4];
            e.last = (r == 3);
            exp_q.push_back(e);
        end
    endtask

    task automatic drain(input int budget, output int cycles);
        cycles = 0;
        while (exp_q.size() != 0 && cycles < budget) begin
            step();
            cycles++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; gen_tick = 1'b0; cells = '0; row_if.row_ready = 1'b0;
        repeat (2) step();
        vectors++;
        if ({row_if.row_valid, busy, overrun, row_if.frame_last, gen_count} !== {4'b0000, 16'h0000}) begin
            miscompares++;
            $display("FAIL reset_state: got valid=%b busy=%b ovr=%b last=%b gen=%h, required all zero",
                     row_if.row_valid, busy, overrun, row_if.frame_last, gen_count);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_blinker();
        int cyc;
        row_if.row_ready = 1'b1;
        cells = 16'h0070; gen_tick = 1'b1;
        push_frame(cells); exp_gen++;
        step();
        gen_tick = 1'b0;
        vectors++;
        if ({row_if.row_valid, row_if.row_idx} !== {1'b1, 2'd0}) begin
            miscompares++;
            $display("FAIL blinker_latency: got valid=%b idx=%0d, required valid=1 idx=0", row_if.row_valid, row_if.row_idx);
        end
        drain(20, cyc);
        vectors++;
        if (cyc !== 4 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL blinker_cycles: got %0d cycles (%0d left), required 4 cycles", cyc, exp_q.size());
        end
        vectors++;
        if ({busy, gen_count} !== {1'b0, exp_gen}) begin
            miscompares++;
            $display("FAIL blinker_end: got busy=%b gen=%h, required busy=0 gen=%h", busy, gen_count, exp_gen);
        end
`ifdef GOL_POPCOUNT_EN
        vectors++;
        if (population !== 5'd3) begin
            miscompares++;
            $display("FAIL blinker_pop: got %0d, required 3", population);
        end
`endif
    endtask

    task automatic test_backpressure();
        int cyc;
        cells = 16'hA5C3; gen_tick = 1'b1;
        push_frame(cells); exp_gen++;
        step();
        gen_tick = 1'b0;
        step();
        row_if.row_ready = 1'b0;
        cells = ~16'hA5C3;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if ({row_if.row_valid, row_if.row_idx, row_if.row_data, row_if.frame_last} !== {1'b1, 2'd1, 4'hC, 1'b0}) begin
                miscompares++;
                $display("FAIL bp_hold[%0d]: got valid=%b idx=%0d data=%h last=%b, required 1/1/c/0",
                         i, row_if.row_valid, row_if.row_idx, row_if.row_data, row_if.frame_last);
            end
        end
        row_if.row_ready = 1'b1;
        drain(20, cyc);
        vectors++;
        if (exp_q.size() != 0 || busy !== 1'b0 || gen_count !== exp_gen) begin
            miscompares++;
            $display("FAIL bp_end: got left=%0d busy=%b gen=%h, required 0/0/%h", exp_q.size(), busy, gen_count, exp_gen);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        cells = 16'h1234; gen_tick = 1'b1;
        push_frame(cells); exp_gen++;
        step();
        gen_tick = 1'b0;
        cyc = 0;
        while (!(row_if.row_valid && row_if.row_idx == 2'd3) && cyc < 10) begin
            step();
            cyc++;
        end
        vectors++;
        if (!(row_if.row_valid && row_if.row_idx == 2'd3)) begin
            miscompares++;
            $display("FAIL b2b_reach_row3: got idx=%0d valid=%b, required idx=3 valid=1", row_if.row_idx, row_if.row_valid);
        end
        cells = 16'hF0E1; gen_tick = 1'b1;
        push_frame(cells); exp_gen++;
        step();
        gen_tick = 1'b0;
        vectors++;
        if ({busy, row_if.row_valid, row_if.row_idx, row_if.row_data, gen_count, overrun} !== {2'b11, 2'd0, 4'h1, exp_gen, 1'b0}) begin
            miscompares++;
            $display("FAIL b2b_next: got busy=%b valid=%b idx=%0d data=%h gen=%h ovr=%b, required 1/1/0/1/%h/0",
                     busy, row_if.row_valid, row_if.row_idx, row_if.row_data, gen_count, overrun, exp_gen);
        end
        drain(20, cyc);
        vectors++;
        if (exp_q.size() != 0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_end: got left=%0d busy=%b, required 0/0", exp_q.size(), busy);
        end
    endtask

    task automatic test_overrun();
        int cyc;
        cells = 16'h9C63; gen_tick = 1'b1;
        push_frame(cells); exp_gen++;
        step();
        gen_tick = 1'b0;
        step();
        gen_tick = 1'b1;
        cells = 16'h0F0F;
        step();
        gen_tick = 1'b0;
        vectors++;
        if ({overrun, gen_count, row_if.row_idx} !== {1'b1, exp_gen, 2'd2}) begin
            miscompares++;
            $display("FAIL overrun_flag: got ovr=%b gen=%h idx=%0d, required 1/%h/2", overrun, gen_count, row_if.row_idx, exp_gen);
        end
        drain(20, cyc);
        vectors++;
        if (exp_q.size() != 0 || {busy, overrun, gen_count} !== {2'b01, exp_gen}) begin
            miscompares++;
            $display("FAIL overrun_end: got left=%0d busy=%b ovr=%b gen=%h, required 0/0/1/%h",
                     exp_q.size(), busy, overrun, gen_count, exp_gen);
        end
    endtask

    task automatic test_wrap_reset();
        int cyc;
        // Preload the counter near its top instead of streaming 65534 frames.
        force dut.gen_count_q = 16'hFFFE;
        step();
        release dut.gen_count_q;
        exp_gen = 16'hFFFE;
        for (int f = 0; f < 2; f++) begin
            cells = 16'h3C3C ^ 16'(f); gen_tick = 1'b1;
            push_frame(cells); exp_gen++;
            step();
            gen_tick = 1'b0;
            drain(20, cyc);
            vectors++;
            if (exp_q.size() != 0 || gen_count !== exp_gen || overrun !== 1'b1) begin
                miscompares++;
                $display("FAIL wrap[%0d]: got left=%0d gen=%h ovr=%b, required 0/%h/1", f, exp_q.size(), gen_count, overrun, exp_gen);
            end
        end
        cells = 16'h5555; gen_tick = 1'b1;
        push_frame(cells);
        step();
        gen_tick = 1'b0;
        step();
        reset = 1'b1; gen_tick = 1'b1;
        step();
        exp_q.delete();
        vectors++;
        if ({row_if.row_valid, busy, overrun, row_if.frame_last, gen_count} !== {4'b0000, 16'h0000}) begin
            miscompares++;
            $display("FAIL midframe_reset: got valid=%b busy=%b ovr=%b last=%b gen=%h, required all zero",
                     row_if.row_valid, busy, overrun, row_if.frame_last, gen_count);
        end
`ifdef GOL_POPCOUNT_EN
        vectors++;
        if (population !== 5'd0) begin
            miscompares++;
            $display("FAIL reset_pop: got %0d, required 0", population);
        end
`endif
        reset = 1'b0; gen_tick = 1'b0;
        step();
        vectors++;
        if (row_if.row_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset_idle: got valid=%b, required 0", row_if.row_valid);
        end
    endtask

    initial begin
        test_reset();
        test_blinker();
        test_backpressure();
        test_back_to_back();
        test_overrun();
        test_wrap_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
